// File: rtl/ms_path_checker.sv
// Scoreboard for the maze solver: snoops the serial maze load, then checks that
// the solver's coordinate stream is a legal open-cell path from (13,13) to (1,1).
module ms_path_checker #(
    parameter int unsigned TO_CYCLES = 2048,
    parameter int unsigned LEN_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             maze,
    input  logic             in_valid,
    input  logic             sol_valid,
    input  logic             sol_not_valid,
    input  logic [3:0]       sol_x,
    input  logic [3:0]       sol_y,
    output logic             chk_done,
    output logic             chk_pass,
    output logic [2:0]       chk_err,
    output logic [LEN_W-1:0] path_len
);

    localparam int unsigned DIM     = 15;
    localparam int unsigned N_CELLS = DIM * DIM;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TO_W    = $clog2(TO_CYCLES + 1);

    localparam logic [2:0] ST_LOAD   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_REPORT = 3'd3;
    localparam logic [2:0] ST_IDLE   = 3'd4;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_START     = 3'd1;
    localparam logic [2:0] ERR_STEP      = 3'd2;
    localparam logic [2:0] ERR_WALL      = 3'd3;
    localparam logic [2:0] ERR_END       = 3'd4;
    localparam logic [2:0] ERR_RANGE     = 3'd5;
    localparam logic [2:0] ERR_NOT_VALID = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd7;

    logic [2:0]         state_q, state_d;
    logic [N_CELLS-1:0] bitmap_q, bitmap_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [2:0]         err_q, err_d;
    logic [3:0]         prev_x_q, prev_x_d;
    logic [3:0]         prev_y_q, prev_y_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [2:0]         verdict_q, verdict_d;

    logic [CNT_W-1:0]   cell_idx_c;
    logic [3:0]         dx_c, dy_c;
    logic [4:0]         dist_c;
    logic               range_c, wall_c, first_c;
    logic [2:0]         beat_err_c;
    logic [2:0]         fin_err_c;
    logic               restart_c;

    // Classify the current solver beat; RANGE masks the bitmap lookup.
    always_comb begin
        cell_idx_c = CNT_W'(sol_y) * CNT_W'(DIM) + CNT_W'(sol_x);
        range_c    = (sol_x > 4'd14) || (sol_y > 4'd14);
        wall_c     = !range_c && bitmap_q[cell_idx_c];
        first_c    = (state_q == ST_WAIT);
        dx_c       = (sol_x >= prev_x_q) ? sol_x - prev_x_q : prev_x_q - sol_x;
        dy_c       = (sol_y >= prev_y_q) ? sol_y - prev_y_q : prev_y_q - sol_y;
        dist_c     = 5'(dx_c) + 5'(dy_c);
        beat_err_c = ERR_NONE;
        if (range_c) begin
            beat_err_c = ERR_RANGE;
        end else if (wall_c) begin
            beat_err_c = ERR_WALL;
        end else if (first_c && !(sol_x == 4'd13 && sol_y == 4'd13)) begin
            beat_err_c = ERR_START;
        end else if (!first_c && dist_c != 5'd1) begin
            beat_err_c = ERR_STEP;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitmap_d   = bitmap_q;
        beat_cnt_d = beat_cnt_q;
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
        prev_x_d   = prev_x_q;
        prev_y_d   = prev_y_q;
        len_d      = len_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        verdict_d  = verdict_q;
        fin_err_c  = err_q;
        restart_c  = in_valid && (state_q == ST_WAIT || state_q == ST_CHECK || state_q == ST_IDLE);

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    bitmap_d[beat_cnt_q] = maze;
                    if (beat_cnt_q == CNT_W'(N_CELLS - 1)) begin
                        beat_cnt_d = '0;
                        to_cnt_d   = '0;
                        state_d    = ST_WAIT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (sol_valid && sol_not_valid) begin
                    state_d   = ST_REPORT;
                    done_d    = 1'b1;
                    verdict_d = ERR_NOT_VALID;
                    pass_d    = 1'b0;
                end else if (sol_valid) begin
                    err_d    = beat_err_c;
                    prev_x_d = sol_x;
                    prev_y_d = sol_y;
                    len_d    = LEN_W'(1);
                    state_d  = ST_CHECK;
                end else if (to_cnt_q == TO_W'(TO_CYCLES)) begin
                    state_d   = ST_REPORT;
                    done_d    = 1'b1;
                    verdict_d = ERR_TIMEOUT;
                    pass_d    = 1'b0;
                end
            end
            ST_CHECK: begin
                if (sol_valid) begin
                    if (len_q != {LEN_W{1'b1}}) begin
                        len_d = len_q + LEN_W'(1);
                    end
                    if (sol_not_valid) begin
                        if (err_q == ERR_NONE) err_d = ERR_NOT_VALID;
                    end else begin
                        if (err_q == ERR_NONE) err_d = beat_err_c;
                        prev_x_d = sol_x;
                        prev_y_d = sol_y;
                    end
                end else begin
                    // End of stream: the last registered beat must be the goal cell.
                    if (err_q == ERR_NONE && !(prev_x_q == 4'd1 && prev_y_q == 4'd1)) begin
                        fin_err_c = ERR_END;
                    end
                    state_d   = ST_REPORT;
                    done_d    = 1'b1;
                    verdict_d = fin_err_c;
                    pass_d    = (fin_err_c == ERR_NONE);
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            ST_IDLE:   state_d = ST_IDLE;
            default:   state_d = ST_LOAD;
        endcase

        // A new maze load pre-empts any check in progress and restarts at bit 0.
        if (restart_c) begin
            bitmap_d[0] = maze;
            beat_cnt_d  = CNT_W'(1);
            len_d       = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            verdict_d   = ERR_NONE;
            state_d     = ST_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            bitmap_q   <= '0;
            beat_cnt_q <= '0;
            to_cnt_q   <= '0;
            err_q      <= ERR_NONE;
            prev_x_q   <= '0;
            prev_y_q   <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            verdict_q  <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            bitmap_q   <= bitmap_d;
            beat_cnt_q <= beat_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
            prev_x_q   <= prev_x_d;
            prev_y_q   <= prev_y_d;
            len_q      <= len_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            verdict_q  <= verdict_d;
        end
    end

    assign chk_done = done_q;
    assign chk_pass = pass_q;
    assign chk_err  = verdict_q;
    assign path_len = len_q;

endmodule

// File: tb/tb_ms_path_checker.sv
// Directed bench for ms_path_checker on a corridor maze: legal path, each error
// code, timeout latency, abort by reload and mid-load reset.
module tb_ms_path_checker;

    localparam int TO = 2048;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       maze = 1'b0;
    logic       in_valid = 1'b0;
    logic       sol_valid = 1'b0;
    logic       sol_not_valid = 1'b0;
    logic [3:0] sol_x = 4'd0;
    logic [3:0] sol_y = 4'd0;
    logic       chk_done;
    logic       chk_pass;
    logic [2:0] chk_err;
    logic [7:0] path_len;

    int n_cmp = 0;
    int n_mis = 0;
    int px[0:31];
    int py[0:31];
    int pn[0:31];
    int np;
    int done_seen;

    ms_path_checker #(.TO_CYCLES(TO), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .maze(maze), .in_valid(in_valid),
        .sol_valid(sol_valid), .sol_not_valid(sol_not_valid),
        .sol_x(sol_x), .sol_y(sol_y), .chk_done(chk_done), .chk_pass(chk_pass),
        .chk_err(chk_err), .path_len(path_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Corridor: row 1 cols 1..13 and col 13 rows 1..13 are open, all else wall.
    function automatic logic is_wall(input int k);
        int r;
        int c;
        r = k / 15;
        c = k % 15;
        return !((r == 1 && c >= 1 && c <= 13) || (c == 13 && r >= 1 && r <= 13));
    endfunction

    function automatic void build_corridor();
        for (int i = 0; i < 13; i++) begin
            px[i] = 13; py[i] = 13 - i; pn[i] = 0;
        end
        for (int i = 13; i < 25; i++) begin
            px[i] = 12 - (i - 13); py[i] = 1; pn[i] = 0;
        end
        np = 25;
    endfunction

    function automatic void drop(input int idx);
        for (int i = idx; i < np - 1; i++) begin
            px[i] = px[i + 1]; py[i] = py[i + 1]; pn[i] = pn[i + 1];
        end
        np--;
    endfunction

    // Streams n maze beats with periodic in_valid gaps; returns on the negedge after the last beat.
    task automatic load_beats(input int n);
        done_seen = 0;
        for (int k = 0; k < n; k++) begin
            if (k % 40 == 39) begin
                in_valid = 1'b0;
                @(negedge clk);
                if (chk_done) done_seen++;
            end
            in_valid = 1'b1;
            maze = is_wall(k);
            @(negedge clk);
            if (chk_done) done_seen++;
        end
        in_valid = 1'b0;
        maze = 1'b0;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            sol_valid = 1'b1;
            sol_not_valid = 1'(pn[i]);
            sol_x = 4'(px[i]);
            sol_y = 4'(py[i]);
            @(negedge clk);
        end
        sol_valid = 1'b0;
        sol_not_valid = 1'b0;
    endtask

    // Full run: load, stream the path, then expect the verdict one cycle after sol_valid drops.
    task automatic run_path(input string tag, input int exp_err, input int exp_len);
        load_beats(225);
        send_beats(np);
        @(negedge clk);
        chk({tag, "_done"}, 32'(chk_done), 32'd1);
        chk({tag, "_pass"}, 32'(chk_pass), (exp_err == 0) ? 32'd1 : 32'd0);
        chk({tag, "_err"},  32'(chk_err),  32'(exp_err));
        chk({tag, "_len"},  32'(path_len), 32'(exp_len));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(chk_done), 32'd0);
    endtask

    initial begin
        int cnt;
        int ndone;
        int err_at_done;

        repeat (3) @(negedge clk);
        chk("rst_done", 32'(chk_done), 32'd0);
        chk("rst_pass", 32'(chk_pass), 32'd0);
        chk("rst_err",  32'(chk_err),  32'd0);
        chk("rst_len",  32'(path_len), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        build_corridor();
        run_path("legal", 0, 25);

        build_corridor();
        px[5] = 12; py[5] = 9;
        run_path("wall", 3, 25);

        build_corridor();
        drop(0);
        run_path("start", 1, 24);

        build_corridor();
        drop(9);
        run_path("step", 2, 24);

        build_corridor();
        drop(24);
        run_path("end", 4, 24);

        build_corridor();
        px[3] = 15;
        run_path("range", 5, 25);

        build_corridor();
        np = 4;
        pn[3] = 1;
        run_path("nv_check", 6, 4);

        // Unsolvable flag held for three cycles while waiting.
        load_beats(225);
        ndone = 0;
        err_at_done = -1;
        for (int i = 0; i < 6; i++) begin
            sol_valid = (i < 3);
            sol_not_valid = (i < 3);
            @(negedge clk);
            if (chk_done) begin
                ndone++;
                err_at_done = int'(chk_err);
            end
        end
        sol_valid = 1'b0;
        sol_not_valid = 1'b0;
        chk("nv_wait_pulses", 32'(ndone), 32'd1);
        chk("nv_wait_err", 32'(err_at_done), 32'd6);
        chk("nv_wait_pass", 32'(chk_pass), 32'd0);

        // Timeout: count cycles after the edge that sampled the last maze bit.
        load_beats(225);
        cnt = 0;
        while (!chk_done && cnt < TO + 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("to_latency", 32'(cnt), 32'(TO + 1));
        chk("to_err", 32'(chk_err), 32'd7);
        chk("to_pass", 32'(chk_pass), 32'd0);
        @(negedge clk);

        // Reload during CHECK abandons the check silently.
        build_corridor();
        load_beats(225);
        send_beats(4);
        load_beats(225);
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_len", 32'(path_len), 32'd0);
        send_beats(np);
        @(negedge clk);
        chk("abort_reload_done", 32'(chk_done), 32'd1);
        chk("abort_reload_pass", 32'(chk_pass), 32'd1);
        chk("abort_reload_len", 32'(path_len), 32'd25);
        @(negedge clk);

        // Reset in the middle of a load; the next load must start at bit 0.
        load_beats(50);
        rst_n = 1'b0;
        #2;
        chk("midrst_done", 32'(chk_done), 32'd0);
        chk("midrst_pass", 32'(chk_pass), 32'd0);
        chk("midrst_err",  32'(chk_err),  32'd0);
        chk("midrst_len",  32'(path_len), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_path("post_rst", 0, 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
